// File: rtl/window_3x3_buffer_pkg.sv
// window_3x3_buffer_pkg: pixel/window constants and coordinate width helper shared with the convolution core
package window_3x3_buffer_pkg;
  localparam int PIXEL_W = 24;
  localparam int WIN_TAPS = 9;
  localparam int TAP_NW = 0, TAP_N = 1, TAP_NE = 2;
  localparam int TAP_W = 3, TAP_C = 4, TAP_E = 5;
  localparam int TAP_SW = 6, TAP_S = 7, TAP_SE = 8;
  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/window_3x3_buffer_if.sv
// window_3x3_buffer_if: raster pixel input and tagged 3x3 window output
interface window_3x3_buffer_if #(
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int PIXEL_W = window_3x3_buffer_pkg::PIXEL_W
);
  import window_3x3_buffer_pkg::*;
  localparam int XW = coord_w(WIDTH);
  localparam int YW = coord_w(HEIGHT);
  logic in_valid;
  logic [PIXEL_W-1:0] in_pixel;
  logic out_valid;
  logic [WIN_TAPS*PIXEL_W-1:0] out_window;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic out_eof;
  modport master (output in_valid, in_pixel, input out_valid, out_window, out_x, out_y, out_eof);
  modport slave (input in_valid, in_pixel, output out_valid, out_window, out_x, out_y, out_eof);
endinterface

// File: rtl/window_3x3_buffer_line_ram.sv
// line_ram: simple dual-port single-clock RAM, read-first with registered read
module line_ram #(
  parameter int DEPTH = 640,
  parameter int DW = 24,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end
endmodule

// File: rtl/window_3x3_buffer.sv
// window_3x3_buffer: raster stream to tagged 3x3 neighbourhood; WINDOW_ZERO_PAD_EN selects zero-padded borders
module window_3x3_buffer #(
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int PIXEL_W = window_3x3_buffer_pkg::PIXEL_W
) (
  input logic daisy_clock,
  input logic reset,
  input logic restart,
  window_3x3_buffer_if.slave bus
);
  import window_3x3_buffer_pkg::*;
  localparam int XW = coord_w(WIDTH);
  localparam int YW = coord_w(HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
`ifdef WINDOW_ZERO_PAD_EN
  localparam bit ZERO_PAD = 1'b1;
`else
  localparam bit ZERO_PAD = 1'b0;
`endif
  logic clr;
  logic [XW-1:0] col, col_cur, col_nxt, x1, x2;
  logic [YW-1:0] row, row_cur, row_nxt, y1, y2;
  logic v1, v2, emit;
  logic [PIXEL_W-1:0] px1, a_q, b_q;
  logic [PIXEL_W-1:0] win [3][3];
  logic [WIN_TAPS*PIXEL_W-1:0] win_m;
  assign clr = reset | restart;
  // a pixel arriving with a resync is taken as (0,0)
  always_comb begin
    col_cur = clr ? '0 : col;
    row_cur = clr ? '0 : row;
    col_nxt = (col_cur == X_LAST) ? '0 : col_cur + XW'(1);
    row_nxt = (col_cur != X_LAST) ? row_cur : (row_cur == Y_LAST) ? '0 : row_cur + YW'(1);
  end
  always_ff @(posedge daisy_clock) begin
    col <= bus.in_valid ? col_nxt : col_cur;
    row <= bus.in_valid ? row_nxt : row_cur;
    v1 <= bus.in_valid;
    if (bus.in_valid) begin
      px1 <= bus.in_pixel;
      x1 <= col_cur;
      y1 <= row_cur;
    end
  end
  line_ram #(.DEPTH(WIDTH), .DW(PIXEL_W), .AW(XW)) u_line_a (
    .clk(daisy_clock), .we(bus.in_valid), .waddr(col_cur), .wdata(bus.in_pixel),
    .raddr(col_cur), .rdata(a_q)
  );
  // lineB takes the old lineA word one cycle later, once the registered read has it
  line_ram #(.DEPTH(WIDTH), .DW(PIXEL_W), .AW(XW)) u_line_b (
    .clk(daisy_clock), .we(v1 & ~clr), .waddr(x1), .wdata(a_q),
    .raddr(col_cur), .rdata(b_q)
  );
  always_ff @(posedge daisy_clock) begin
    v2 <= v1 & ~clr;
    if (v1) begin
      x2 <= x1;
      y2 <= y1;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= b_q;
      win[1][2] <= a_q;
      win[2][2] <= px1;
    end
  end
  always_comb begin
    win_m = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win_m[(3*r+c)*PIXEL_W +: PIXEL_W] =
          (!ZERO_PAD || (int'(y2) + r >= 2 && int'(x2) + c >= 2)) ? win[r][c] : '0;
    emit = ZERO_PAD || (int'(x2) >= 2 && int'(y2) >= 2);
  end
  always_ff @(posedge daisy_clock) begin
    if (clr) begin
      bus.out_valid <= 1'b0;
      bus.out_eof <= 1'b0;
      bus.out_window <= '0;
      bus.out_x <= '0;
      bus.out_y <= '0;
    end else begin
      bus.out_valid <= v2 & emit;
      bus.out_eof <= v2 && x2 == X_LAST && y2 == Y_LAST;
      if (v2) begin
        bus.out_window <= win_m;
        bus.out_x <= x2;
        bus.out_y <= y2;
      end
    end
  end
endmodule

// File: tb/tb_window_3x3_buffer.sv
// tb_window_3x3_buffer: directed frames against a coordinate-indexed image model of the 3x3 window
module tb_window_3x3_buffer;
  localparam int W = 4, H = 3, PW = 24, WW = 9 * PW;
`ifdef WINDOW_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
  localparam int PER_FRAME = W * H;
`else
  localparam bit PAD = 1'b0;
  localparam int PER_FRAME = (W - 2) * (H - 2);
`endif
  localparam logic [WW-1:0] L22 = {24'h22, 24'h21, 24'h20, 24'h12, 24'h11, 24'h10, 24'h02, 24'h01, 24'h00};
  localparam logic [WW-1:0] L32 = {24'h23, 24'h22, 24'h21, 24'h13, 24'h12, 24'h11, 24'h03, 24'h02, 24'h01};
  localparam logic [WW-1:0] L11 = {24'h11, 24'h10, 24'h00, 24'h01, 24'h00, 24'h00, 24'h00, 24'h00, 24'h00};
  logic clk = 0, reset = 1, restart = 0;
  always #5 clk = ~clk;
  window_3x3_buffer_if #(.WIDTH(W), .HEIGHT(H), .PIXEL_W(PW)) bus ();
  window_3x3_buffer #(.WIDTH(W), .HEIGHT(H), .PIXEL_W(PW)) dut (
    .daisy_clock(clk), .reset(reset), .restart(restart), .bus(bus)
  );
  typedef struct {
    int due;
    int x;
    int y;
    bit emit;
    logic [WW-1:0] win;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0, cyc = 0, mx = 0, my = 0, since = 0, yy, xx;
  bit zero_hold = 0;
  logic [PW-1:0] img [H][W];
  task automatic check(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, req);
    end
  endtask
  // model: each accepted pixel lands in img at its raster position; its window is read straight from img
  always @(posedge clk) begin
    cyc++;
    if (reset || restart) begin
      q.delete();
      mx = 0;
      my = 0;
      since = 0;
      zero_hold = 1;
    end
    if (bus.in_valid) begin
      img[my][mx] = bus.in_pixel;
      e.due = cyc + 2;
      e.x = mx;
      e.y = my;
      e.emit = PAD || (mx >= 2 && my >= 2);
      e.win = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          yy = my - 2 + r;
          xx = mx - 2 + c;
          if (yy >= 0 && xx >= 0) e.win[(3*r+c)*PW +: PW] = img[yy][xx];
        end
      q.push_back(e);
      if (mx == W - 1) begin
        mx = 0;
        my = (my == H - 1) ? 0 : my + 1;
      end else mx++;
    end
    #1;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      zero_hold = 0;
      check("out_valid", WW'(bus.out_valid), WW'(e.emit));
      check("out_x", WW'(bus.out_x), WW'(e.x));
      check("out_y", WW'(bus.out_y), WW'(e.y));
      check("out_eof", WW'(bus.out_eof), WW'(e.x == W - 1 && e.y == H - 1));
      if (e.emit) begin
        since++;
        check("window", bus.out_window, e.win);
        if (e.x == 2 && e.y == 2) check("pin_22", bus.out_window, L22);
        if (e.x == 3 && e.y == 2) check("pin_32", bus.out_window, L32);
`ifdef WINDOW_ZERO_PAD_EN
        if (e.x == 0 && e.y == 0) check("pin_00", bus.out_window, '0);
        if (e.x == 1 && e.y == 1) check("pin_11", bus.out_window, L11);
`endif
        if (e.x == W - 1 && e.y == H - 1) begin
          check("frame_count", WW'(since), WW'(PER_FRAME));
          since = 0;
        end
      end
    end else begin
      check("idle_valid", WW'(bus.out_valid), '0);
      if (zero_hold) begin
        check("rst_window", bus.out_window, '0);
        check("rst_tags", WW'({bus.out_x, bus.out_y, bus.out_eof}), '0);
      end
    end
  end
  task automatic pix(input int v, input bit rs);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_pixel = PW'(v);
    restart = rs;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      restart = 1'b0;
    end
  endtask
  task automatic run(input int from, input int to, input int gap, input bit rs_first);
    for (int k = from; k < to; k++) begin
      pix(16 * (k / W) + k % W, rs_first && k == from);
      if (gap > 0) idle($urandom_range(0, gap));
    end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_pixel = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(2);
    run(0, 12, 0, 0);
    idle(4);
    run(0, 12, 3, 0);
    idle(4);
    run(0, 12, 0, 0);
    run(0, 12, 0, 0);
    idle(4);
    run(0, 6, 0, 0);
    run(0, 12, 0, 1);
    idle(4);
    run(0, 11, 0, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    run(0, 12, 0, 0);
    idle(6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
